spi_tx_sched: RTL and testbench

- Round-robin SPI transmit scheduler that shares one SPI link between NREQ requesters and drives the SPI_Slave receiver.
- Selects a requester, captures its N-bit word, and generates start, SCK and MOSI so the slave receives exactly one word per frame.
- Sits in the clk domain on the master side; its SCK/MOSI/start outputs connect directly to the slave's SCK/MOSI/start inputs.

---
 rtl/spi_tx_sched.sv | 142 ++++++++++++++
 tb/tb_spi_tx_sched.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sched.sv
// Round-robin SPI transmit scheduler: arbitrates NREQ requesters onto one
// SPI link and serialises the captured word MSB first as
// START, N data bits, TAIL, then an idle GAP.
module spi_tx_sched #(
  parameter int N       = 8,
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NREQ-1:0]                          req,
  input  logic [NREQ*N-1:0]                        req_data,
  output logic [NREQ-1:0]                          gnt,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] cur_id,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     sck,
  output logic                                     mosi,
  output logic                                     start
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(N + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_TAIL,
    S_GAP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic              sck_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic              any_req;
  logic              half_end;
  logic              period_end;
  logic              last_bit;
  logic              gap_end;
  logic [N-1:0]      tx_reg;
  int                idx;

  assign any_req    = |req;
  assign half_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign period_end = sck_q & half_end;
  assign last_bit   = (bit_cnt == BIT_W'(N - 1));
  assign gap_end    = (gap_cnt == GAP_W'(GAP_CYC - 1));

  assign sck   = sck_q;
  assign start = (state == S_START);
  assign mosi  = (state == S_SHIFT) & tx_reg[N-1];
  assign busy  = (state != S_IDLE);

  // Round-robin pick: scan downward so the requester nearest ptr+1 wins last.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) win = ID_W'(idx);
    end
  end

  // Next-state logic: frame phases advance on SCK period boundaries.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (any_req) state_n = S_START;
      S_START: if (period_end) state_n = S_SHIFT;
      S_SHIFT: if (period_end && last_bit) state_n = S_TAIL;
      S_TAIL:  if (period_end) state_n = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Control registers: state, SCK divider, bit/gap counters, arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      sck_q      <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ptr        <= ID_W'(NREQ - 1);
      cur_id     <= '0;
      gnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      gnt        <= '0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          sck_q   <= 1'b0;
          bit_cnt <= '0;
          gap_cnt <= '0;
          if (any_req) begin
            gnt    <= NREQ'(1) << win;
            cur_id <= win;
            ptr    <= win;
          end
        end
        S_START, S_SHIFT, S_TAIL: begin
          if (half_end) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (period_end && state == S_SHIFT)
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (period_end && state == S_TAIL)
            frame_done <= 1'b1;
        end
        S_GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shift register: load the winner's word, shift after each data high phase.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && any_req)
      tx_reg <= req_data[int'(win)*N +: N];
    else if (state == S_SHIFT && period_end)
      tx_reg <= {tx_reg[N-2:0], 1'b0};
  end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Testbench for spi_tx_sched: a default instance (CLK_DIV=2) and a fast
// instance (CLK_DIV=1), each observed by a receiver model on SCK rising edges.
module tb_spi_tx_sched;

  localparam int N     = 8;
  localparam int NREQ  = 2;
  localparam int CD    = 2;
  localparam int GAP   = 2;
  localparam int FRAME = (N + 2) * 2 * CD;
  localparam int FRAME1 = (N + 2) * 2 * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [NREQ-1:0] req, req1;
  logic [NREQ*N-1:0] req_data, req_data1;
  logic [NREQ-1:0] gnt, gnt1;
  logic [0:0]      cur_id, cur_id1;
  logic busy, frame_done, sck, mosi, start;
  logic busy1, frame_done1, sck1, mosi1, start1;

  spi_tx_sched #(.N(N), .NREQ(NREQ), .CLK_DIV(CD), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .cur_id(cur_id), .busy(busy), .frame_done(frame_done), .sck(sck),
    .mosi(mosi), .start(start));

  spi_tx_sched #(.N(N), .NREQ(NREQ), .CLK_DIV(1), .GAP_CYC(GAP)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_data(req_data1), .gnt(gnt1),
    .cur_id(cur_id1), .busy(busy1), .frame_done(frame_done1), .sck(sck1),
    .mosi(mosi1), .start(start1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mptr = NREQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model for the default instance
  logic         m_sck_prev = 1'b0;
  int           m_rise = 0;
  logic [N-1:0] m_word = '0;
  bit           m_ok = 1'b0;
  logic [NREQ-1:0] m_gnt_prev = '0;
  int           m_gnt_long = 0;
  int           m_onehot_bad = 0;
  logic [N-1:0] q_word[$];
  int           q_edges[$];
  bit           q_ok[$];
  int           q_done_cyc[$];
  int           q_gnt_id[$];
  int           q_gnt_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      m_rise = 0;
      m_sck_prev = 1'b0;
      m_gnt_prev = '0;
    end else begin
      if (sck && !m_sck_prev) begin
        m_rise++;
        if (m_rise == 1) m_ok = start && !mosi;
        else if (m_rise <= N + 1) begin
          m_word = {m_word[N-2:0], mosi};
          if (start) m_ok = 1'b0;
        end else if (start || mosi) m_ok = 1'b0;
      end
      m_sck_prev = sck;
      if (gnt != 0) begin
        if ($countones(gnt) != 1) m_onehot_bad++;
        if (m_gnt_prev != 0) m_gnt_long++;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) q_gnt_id.push_back(i);
        q_gnt_cyc.push_back(cyc);
      end
      m_gnt_prev = gnt;
      if (frame_done) begin
        q_word.push_back(m_word);
        q_edges.push_back(m_rise);
        q_ok.push_back(m_ok);
        q_done_cyc.push_back(cyc);
        m_rise = 0;
      end
    end
  end

  // Receiver model for the CLK_DIV=1 instance
  logic         m1_sck_prev = 1'b0;
  int           m1_rise = 0;
  logic [N-1:0] m1_word = '0;
  logic [N-1:0] q1_word[$];
  int           q1_edges[$];
  int           q1_done_cyc[$];
  int           q1_gnt_id[$];
  int           q1_gnt_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      m1_rise = 0;
      m1_sck_prev = 1'b0;
    end else begin
      if (sck1 && !m1_sck_prev) begin
        m1_rise++;
        if (m1_rise >= 2 && m1_rise <= N + 1) m1_word = {m1_word[N-2:0], mosi1};
      end
      m1_sck_prev = sck1;
      if (gnt1 != 0) begin
        for (int i = 0; i < NREQ; i++) if (gnt1[i]) q1_gnt_id.push_back(i);
        q1_gnt_cyc.push_back(cyc);
      end
      if (frame_done1) begin
        q1_word.push_back(m1_word);
        q1_edges.push_back(m1_rise);
        q1_done_cyc.push_back(cyc);
        m1_rise = 0;
      end
    end
  end

  // Round-robin reference: first set request scanning upward from p+1.
  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic clear_q();
    q_word.delete(); q_edges.delete(); q_ok.delete(); q_done_cyc.delete();
    q_gnt_id.delete(); q_gnt_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    req = 2'b01;
    req1 = 2'b01;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, cur_id, busy, frame_done, sck, mosi, start} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b required 0", c,
                 {gnt, cur_id, busy, frame_done, sck, mosi, start});
      end
      checks++;
      if ({gnt1, cur_id1, busy1, frame_done1, sck1, mosi1, start1} !== '0) begin
        errors++;
        $display("FAIL reset_outputs_fast cycle %0d got %b required 0", c,
                 {gnt1, cur_id1, busy1, frame_done1, sck1, mosi1, start1});
      end
    end
    reset = 1'b0;
    req = '0;
    req1 = '0;
    mptr = NREQ - 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    int exp_id;
    logic [N-1:0] exp_w;
    repeat (4) @(negedge clk);
    clear_q();
    req_data = {8'hC3, 8'h3C};
    req = 2'b11;
    for (int i = 0; i < 400 && q_gnt_id.size() < 4; i++) @(negedge clk);
    req = '0;
    for (int i = 0; i < 200 && q_word.size() < 4; i++) @(negedge clk);
    #1;
    checks++;
    if (q_word.size() != 4 || q_gnt_id.size() != 4) begin
      errors++;
      $display("FAIL contention_count frames %0d grants %0d required 4",
               q_word.size(), q_gnt_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_id = rr_pick(2'b11, mptr);
        mptr = exp_id;
        exp_w = req_data[exp_id*N +: N];
        checks++;
        if (q_gnt_id[k] != exp_id) begin
          errors++;
          $display("FAIL contention_order %0d got %0d required %0d", k, q_gnt_id[k], exp_id);
        end
        checks++;
        if (q_word[k] !== exp_w) begin
          errors++;
          $display("FAIL contention_word %0d got %h required %h", k, q_word[k], exp_w);
        end
        if (k > 0) begin
          checks++;
          if (q_gnt_cyc[k] - q_gnt_cyc[k-1] != FRAME + GAP + 1) begin
            errors++;
            $display("FAIL contention_spacing %0d got %0d required %0d", k,
                     q_gnt_cyc[k] - q_gnt_cyc[k-1], FRAME + GAP + 1);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    bit got;
    int g_cyc;
    repeat (4) @(negedge clk);
    clear_q();
    req_data[0 +: N] = 8'hA5;
    req = 2'b01;
    got = 0;
    g_cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_gnt_timeout got none required 01");
    end else begin
      g_cyc = cyc;
      checks++;
      if (gnt !== 2'b01 || cur_id !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_capture got gnt=%b id=%b busy=%b required 01/0/1", gnt, cur_id, busy);
      end
      mptr = 0;
      req = '0;
      req_data[0 +: N] = N'($urandom);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
        errors++;
        $display("FAIL single_gnt_pulse got %b required 00", gnt);
      end
      for (int i = 0; i < 100 && q_word.size() < 1; i++) @(negedge clk);
      #1;
      checks++;
      if (q_word.size() != 1) begin
        errors++;
        $display("FAIL single_frame_count got %0d required 1", q_word.size());
      end else begin
        checks++;
        if (q_word[0] !== 8'hA5) begin
          errors++;
          $display("FAIL single_word got %h required a5", q_word[0]);
        end
        checks++;
        if (q_edges[0] != N + 2 || !q_ok[0]) begin
          errors++;
          $display("FAIL single_edges got %0d start_ok=%0d required %0d/1", q_edges[0], q_ok[0], N + 2);
        end
        checks++;
        if (q_done_cyc[0] - g_cyc != FRAME) begin
          errors++;
          $display("FAIL single_latency got %0d required %0d", q_done_cyc[0] - g_cyc, FRAME);
        end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sck !== 1'b0) begin
        errors++;
        $display("FAIL single_idle_after got busy=%b sck=%b required 0/0", busy, sck);
      end
    end
  endtask

  task automatic test_fairness();
    bit got;
    int exp_id;
    logic [N-1:0] exp_w[$];
    repeat (4) @(negedge clk);
    clear_q();
    req_data = {N'($urandom), N'($urandom)};
    req = 2'b10;
    for (int r = 0; r < 3; r++) begin
      if (r == 1) req = 2'b11;
      got = 0;
      for (int i = 0; i < 120 && !got; i++) begin
        @(negedge clk);
        if (gnt != 0) got = 1;
      end
      exp_id = rr_pick(req, mptr);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL fair_gnt_timeout round %0d", r);
      end else if (gnt !== NREQ'(1) << exp_id) begin
        errors++;
        $display("FAIL fair_gnt round %0d got %b required %b", r, gnt, NREQ'(1) << exp_id);
      end
      mptr = exp_id;
      exp_w.push_back(req_data[exp_id*N +: N]);
      if (r == 0 || r == 2) req = '0;
    end
    for (int i = 0; i < 200 && q_word.size() < 3; i++) @(negedge clk);
    #1;
    checks++;
    if (q_word.size() != 3) begin
      errors++;
      $display("FAIL fair_frames got %0d required 3", q_word.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (q_word[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL fair_word %0d got %h required %h", k, q_word[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit got;
    int exp_id;
    logic [N-1:0] exp_w[$];
    repeat (4) @(negedge clk);
    clear_q();
    for (int r = 0; r < 10; r++) begin
      if (req == 0) begin
        req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        for (int id = 0; id < NREQ; id++) req_data[id*N +: N] = N'($urandom);
      end
      if (req == 0) begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          checks++;
          if (gnt !== '0) begin
            errors++;
            $display("FAIL rand_idle_gnt got %b required 00", gnt);
          end
        end
      end else begin
        got = 0;
        for (int i = 0; i < 120 && !got; i++) begin
          @(negedge clk);
          if (gnt != 0) got = 1;
        end
        exp_id = rr_pick(req, mptr);
        checks++;
        if (!got) begin
          errors++;
          $display("FAIL rand_gnt_timeout round %0d", r);
        end else begin
          checks++;
          if (gnt !== NREQ'(1) << exp_id || cur_id !== 1'(exp_id)) begin
            errors++;
            $display("FAIL rand_gnt round %0d got %b id %0d required id %0d", r, gnt, cur_id, exp_id);
          end
          mptr = exp_id;
          exp_w.push_back(req_data[exp_id*N +: N]);
          req[exp_id] = 1'($urandom_range(0, 1));
          req_data[exp_id*N +: N] = N'($urandom);
        end
      end
    end
    req = '0;
    for (int i = 0; i < 300 && q_word.size() < exp_w.size(); i++) @(negedge clk);
    #1;
    checks++;
    if (q_word.size() != exp_w.size()) begin
      errors++;
      $display("FAIL rand_frames got %0d required %0d", q_word.size(), exp_w.size());
    end else begin
      for (int k = 0; k < exp_w.size(); k++) begin
        checks++;
        if (q_word[k] !== exp_w[k] || q_done_cyc[k] - q_gnt_cyc[k] != FRAME) begin
          errors++;
          $display("FAIL rand_word %0d got %h lat %0d required %h lat %0d", k, q_word[k],
                   q_done_cyc[k] - q_gnt_cyc[k], exp_w[k], FRAME);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int fd;
    repeat (4) @(negedge clk);
    clear_q();
    req_data[0 +: N] = N'($urandom);
    req = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    req = '0;
    for (int i = 0; i < 100 && m_rise < 4; i++) @(negedge clk);
    checks++;
    if (!got || m_rise < 4) begin
      errors++;
      $display("FAIL midrst_setup got gnt_seen=%0d rises=%0d required 1/4", got, m_rise);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sck, start, busy, frame_done, gnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %b required 0", {sck, start, busy, frame_done, gnt});
    end
    reset = 1'b0;
    mptr = NREQ - 1;
    fd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    checks++;
    if (fd != 0) begin
      errors++;
      $display("FAIL midrst_no_done got %0d required 0", fd);
    end
    clear_q();
    req_data[N +: N] = 8'h81;
    req = 2'b10;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    checks++;
    if (!got || gnt !== 2'b10) begin
      errors++;
      $display("FAIL midrst_regrant got %b required 10", gnt);
    end
    mptr = 1;
    req = '0;
    for (int i = 0; i < 100 && q_word.size() < 1; i++) @(negedge clk);
    #1;
    checks++;
    if (q_word.size() != 1) begin
      errors++;
      $display("FAIL midrst_frames got %0d required 1", q_word.size());
    end else if (q_word[0] !== 8'h81 || q_edges[0] != N + 2) begin
      errors++;
      $display("FAIL midrst_word got %h edges %0d required 81 edges %0d", q_word[0], q_edges[0], N + 2);
    end
  endtask

  task automatic test_clkdiv1();
    bit got;
    logic s;
    q1_word.delete(); q1_edges.delete(); q1_done_cyc.delete();
    q1_gnt_id.delete(); q1_gnt_cyc.delete();
    req_data1 = '0;
    req1 = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt1 != 0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fast_gnt_timeout");
    end
    req_data1[0 +: N] = 8'hFF;
    s = sck1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sck1 !== ~s) begin
        errors++;
        $display("FAIL fast_sck_toggle %0d got %b required %b", i, sck1, ~s);
      end
      s = sck1;
    end
    for (int i = 0; i < 60 && q1_gnt_id.size() < 2; i++) @(negedge clk);
    req1 = '0;
    for (int i = 0; i < 60 && q1_word.size() < 2; i++) @(negedge clk);
    #1;
    checks++;
    if (q1_word.size() != 2 || q1_gnt_cyc.size() != 2) begin
      errors++;
      $display("FAIL fast_frames got %0d required 2", q1_word.size());
    end else begin
      checks++;
      if (q1_word[0] !== 8'h00 || q1_word[1] !== 8'hFF) begin
        errors++;
        $display("FAIL fast_words got %h %h required 00 ff", q1_word[0], q1_word[1]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (q1_done_cyc[k] - q1_gnt_cyc[k] != FRAME1 || q1_edges[k] != N + 2) begin
          errors++;
          $display("FAIL fast_latency %0d got %0d edges %0d required %0d edges %0d", k,
                   q1_done_cyc[k] - q1_gnt_cyc[k], q1_edges[k], FRAME1, N + 2);
        end
      end
      checks++;
      if (q1_gnt_cyc[1] - q1_gnt_cyc[0] != FRAME1 + GAP + 1) begin
        errors++;
        $display("FAIL fast_spacing got %0d required %0d", q1_gnt_cyc[1] - q1_gnt_cyc[0], FRAME1 + GAP + 1);
      end
    end
  endtask

  task automatic test_pulse_props();
    checks++;
    if (m_gnt_long != 0 || m_onehot_bad != 0) begin
      errors++;
      $display("FAIL gnt_pulse_shape got long=%0d bad_onehot=%0d required 0/0", m_gnt_long, m_onehot_bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req1 = '0;
    req_data = '0;
    req_data1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mptr = NREQ - 1;
    repeat (2) @(negedge clk);
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_random();
    test_reset_mid();
    test_clkdiv1();
    test_pulse_props();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
